// File: rtl/mt_maint_reg.sv
// MT maintenance register: holds the MM/MOP fields, generates the BPI clock
// from a programmable divider, and produces maintenance-clock single steps.
module mt_maint_reg #(
    parameter int          MDFW   = 9,
    parameter int          DIVW   = 11,
    parameter int          DIVRST = 1050,
    parameter int          MCSTR  = 4,
    parameter int          CNTW   = 8,
    parameter logic [3:0]  FRZOP  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [35:0]       mtDATAI,
    input  logic              mtmrWRITE,
    input  logic [MDFW-1:0]   mtMDF,
    input  logic              divLOAD,
    input  logic [DIVW-1:0]   divVAL,
    output logic [MDFW+6:0]   mtMR,
    output logic              mtBPICLK,
    output logic              mtBPIEDGE,
    output logic              mtMCPULSE,
    output logic [CNTW-1:0]   mtMCCNT
);

    localparam logic [DIVW-1:0] DIV_INIT = DIVW'(DIVRST);
    localparam logic [3:0]      STR_INIT = 4'(MCSTR);

    logic            mm_reg;
    logic [3:0]      mop_reg;
    logic            mc_pulse_reg;
    logic [3:0]      stretch_reg;
    logic [CNTW-1:0] mc_cnt_reg;
    logic [DIVW-1:0] div_reg;
    logic [DIVW-1:0] count_reg;
    logic            bpiclk_reg;
    logic            bpi_edge_reg;

    logic            mm_next;
    logic [3:0]      mop_next;
    logic            step;
    logic            frozen;
    logic            frozen_next;
    logic            auto_toggle;
    logic            toggle;
    logic            unused_data;

    assign mm_next     = mtmrWRITE ? mtDATAI[0]   : mm_reg;
    assign mop_next    = mtmrWRITE ? mtDATAI[4:1] : mop_reg;
    assign step        = mtmrWRITE & mtDATAI[5] & mtDATAI[0];
    assign frozen      = mm_reg & (mop_reg == FRZOP);
    assign frozen_next = mm_next & (mop_next == FRZOP);

    // A step toggles BPICLK in the same cycle its pulse is visible, so it is
    // judged against the freeze state that the same write establishes.
    assign auto_toggle = ~frozen & (count_reg == '0);
    assign toggle      = ~divLOAD & (auto_toggle | (step & frozen_next));

    assign unused_data = ^mtDATAI[35:6];

    always_ff @(posedge clk) begin
        if (rst) begin
            mm_reg       <= 1'b0;
            mop_reg      <= 4'h0;
            mc_pulse_reg <= 1'b0;
            stretch_reg  <= 4'h0;
            mc_cnt_reg   <= '0;
            div_reg      <= DIV_INIT;
            count_reg    <= DIV_INIT;
            bpiclk_reg   <= 1'b0;
            bpi_edge_reg <= 1'b0;
        end else begin
            mm_reg       <= mm_next;
            mop_reg      <= mop_next;
            mc_pulse_reg <= step;

            if (step)
                stretch_reg <= STR_INIT;
            else if (stretch_reg != 4'h0)
                stretch_reg <= stretch_reg - 4'h1;

            if (step)
                mc_cnt_reg <= mc_cnt_reg + 1'b1;
            else if (mtmrWRITE && !mtDATAI[0])
                mc_cnt_reg <= '0;

            // A load always wins over the reload/decrement path.
            if (divLOAD) begin
                div_reg   <= divVAL;
                count_reg <= divVAL;
            end else if (!frozen) begin
                if (count_reg == '0)
                    count_reg <= div_reg;
                else
                    count_reg <= count_reg - 1'b1;
            end

            bpi_edge_reg <= toggle;
            bpiclk_reg   <= bpiclk_reg ^ toggle;
        end
    end

    assign mtMR      = {mtMDF, bpiclk_reg, (stretch_reg != 4'h0), mop_reg, mm_reg};
    assign mtBPICLK  = bpiclk_reg;
    assign mtBPIEDGE = bpi_edge_reg;
    assign mtMCPULSE = mc_pulse_reg;
    assign mtMCCNT   = mc_cnt_reg;

endmodule

// File: tb/tb_mt_maint_reg.sv
// Self-checking bench for mt_maint_reg: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the register.
module tb_mt_maint_reg;

    localparam int DIVRST = 1050;
    localparam int MCSTR  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] mtDATAI;
    logic        mtmrWRITE;
    logic [8:0]  mtMDF;
    logic        divLOAD;
    logic [10:0] divVAL;
    logic [15:0] mtMR;
    logic        mtBPICLK;
    logic        mtBPIEDGE;
    logic        mtMCPULSE;
    logic [7:0]  mtMCCNT;

    mt_maint_reg dut (
        .clk       (clk),
        .rst       (rst),
        .mtDATAI   (mtDATAI),
        .mtmrWRITE (mtmrWRITE),
        .mtMDF     (mtMDF),
        .divLOAD   (divLOAD),
        .divVAL    (divVAL),
        .mtMR      (mtMR),
        .mtBPICLK  (mtBPICLK),
        .mtBPIEDGE (mtBPIEDGE),
        .mtMCPULSE (mtMCPULSE),
        .mtMCCNT   (mtMCCNT)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int edges_q[$];

    // Behavioural model: m_left is the number of cycles until the next
    // automatic BPICLK toggle.
    int m_mm, m_mop, m_pulse, m_edge, m_bpi, m_stretch, m_cnt, m_div, m_left;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_update();
        int  nmm, nmop;
        bit  frz_now, frz_new, stp, tog;
        if (rst) begin
            m_mm = 0; m_mop = 0; m_pulse = 0; m_edge = 0; m_bpi = 0;
            m_stretch = 0; m_cnt = 0; m_div = DIVRST; m_left = DIVRST + 1;
            cyc = 0;
            return;
        end
        cyc++;
        frz_now = (m_mm == 1) && (m_mop == 15);
        nmm     = mtmrWRITE ? int'(mtDATAI[0])   : m_mm;
        nmop    = mtmrWRITE ? int'(mtDATAI[4:1]) : m_mop;
        frz_new = (nmm == 1) && (nmop == 15);
        stp     = mtmrWRITE && mtDATAI[5] && mtDATAI[0];
        tog     = !divLOAD && ((!frz_now && m_left == 1) || (stp && frz_new));
        if (divLOAD) begin
            m_div  = int'(divVAL);
            m_left = m_div + 1;
        end else if (!frz_now) begin
            m_left = (m_left == 1) ? m_div + 1 : m_left - 1;
        end
        m_edge    = tog ? 1 : 0;
        m_bpi     = tog ? 1 - m_bpi : m_bpi;
        m_pulse   = stp ? 1 : 0;
        m_stretch = stp ? MCSTR : (m_stretch > 0 ? m_stretch - 1 : 0);
        if (stp)
            m_cnt = (m_cnt + 1) % 256;
        else if (mtmrWRITE && !mtDATAI[0])
            m_cnt = 0;
        m_mm  = nmm;
        m_mop = nmop;
    endtask

    task automatic compare();
        logic [15:0] exp_mr;
        logic [3:0]  mop4;
        mop4   = 4'(m_mop);
        exp_mr = {mtMDF, (m_bpi == 1), (m_stretch != 0), mop4, (m_mm == 1)};
        chk("mr", 64'(mtMR), 64'(exp_mr));
        chk("bpiclk", 64'(mtBPICLK), 64'(m_bpi));
        chk("bpiedge", 64'(mtBPIEDGE), 64'(m_edge));
        chk("mcpulse", 64'(mtMCPULSE), 64'(m_pulse));
        chk("mccnt", 64'(mtMCCNT), 64'(m_cnt));
        if (mtBPIEDGE) edges_q.push_back(cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic mr_write(input logic [35:0] data);
        mtmrWRITE = 1'b1;
        mtDATAI   = data;
        tick();
        mtmrWRITE = 1'b0;
        $display("write MR data=%0o -> MR=%0h pulse=%0b cnt=%0d cycle=%0d",
                 data, mtMR, mtMCPULSE, mtMCCNT, cyc);
    endtask

    initial begin
        int t_load;
        int found;
        rst = 1'b1; mtDATAI = '0; mtmrWRITE = 1'b0; mtMDF = 9'h1A5;
        divLOAD = 1'b0; divVAL = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("reset_mr", 64'(mtMR), 64'({9'h1A5, 7'b0}));
        chk("reset_cnt", 64'(mtMCCNT), 64'd0);
        chk("reset_pulse", 64'(mtMCPULSE), 64'd0);
        chk("reset_bpiclk", 64'(mtBPICLK), 64'd0);

        // Free-running divider from the reset divisor
        edges_q.delete();
        repeat (4400) tick();
        chk("t1_edges", 64'(edges_q.size()), 64'd4);
        if (edges_q.size() == 4) begin
            chk("t1_edge0", 64'(edges_q[0]), 64'd1051);
            chk("t1_edge1", 64'(edges_q[1]), 64'd2102);
            chk("t1_edge2", 64'(edges_q[2]), 64'd3153);
            chk("t1_edge3", 64'(edges_q[3]), 64'd4204);
        end
        $display("divider idle run done, %0d toggles", edges_q.size());

        // Load divisor 3 mid-count
        t_load  = cyc;
        divLOAD = 1'b1; divVAL = 11'd3;
        tick();
        divLOAD = 1'b0;
        edges_q.delete();
        repeat (19) tick();
        chk("t2_edges", 64'(edges_q.size()), 64'd4);
        if (edges_q.size() == 4) begin
            chk("t2_first", 64'(edges_q[0] - t_load), 64'd5);
            chk("t2_spacing", 64'(edges_q[1] - edges_q[0]), 64'd4);
        end

        // Load coinciding with count==0 suppresses the toggle
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick();
            if (mtBPIEDGE) found = 1;
        end
        chk("t2_wait_edge", 64'(found), 64'd1);
        repeat (3) tick();
        divLOAD = 1'b1; divVAL = 11'd3;
        tick();
        divLOAD = 1'b0;
        chk("t2_load_no_edge", 64'(mtBPIEDGE), 64'd0);
        repeat (3) tick();
        chk("t2_quiet", 64'(mtBPIEDGE), 64'd0);
        tick();
        chk("t2_resume", 64'(mtBPIEDGE), 64'd1);

        // MC steps
        mr_write(36'o0);
        mr_write(36'o41);
        chk("t3_pulse1", 64'(mtMCPULSE), 64'd1);
        chk("t3_mcbit1", 64'(mtMR[5]), 64'd1);
        chk("t3_cnt1", 64'(mtMCCNT), 64'd1);
        chk("t3_mm", 64'(mtMR[0]), 64'd1);
        tick();
        chk("t3_pulse_off", 64'(mtMCPULSE), 64'd0);
        chk("t3_mcbit2", 64'(mtMR[5]), 64'd1);
        mr_write(36'o41);
        chk("t3_pulse2", 64'(mtMCPULSE), 64'd1);
        chk("t3_cnt2", 64'(mtMCCNT), 64'd2);
        repeat (3) tick();
        chk("t3_mcbit_held", 64'(mtMR[5]), 64'd1);
        tick();
        chk("t3_mcbit_clear", 64'(mtMR[5]), 64'd0);

        // Freeze
        mr_write(36'o37);
        edges_q.delete();
        repeat (3000) tick();
        chk("t4_frozen_edges", 64'(edges_q.size()), 64'd0);
        edges_q.delete();
        mr_write(36'o77);
        chk("t4_step_edge", 64'(mtBPIEDGE), 64'd1);
        mr_write(36'o77);
        mr_write(36'o77);
        repeat (4) tick();
        chk("t4_step_edges", 64'(edges_q.size()), 64'd3);

        // MC request ignored with MM=0, count cleared; wrap
        mr_write(36'o40);
        chk("t5_no_pulse", 64'(mtMCPULSE), 64'd0);
        chk("t5_cnt_clear", 64'(mtMCCNT), 64'd0);
        for (int i = 0; i < 255; i++) mr_write(36'o41);
        chk("t5_cnt255", 64'(mtMCCNT), 64'd255);
        mr_write(36'o41);
        chk("t5_wrap", 64'(mtMCCNT), 64'd0);

        // Reset during stretch and freeze
        mr_write(36'o77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_mr", 64'(mtMR), 64'({mtMDF, 7'b0}));
        chk("t6_pulse", 64'(mtMCPULSE), 64'd0);
        chk("t6_edge", 64'(mtBPIEDGE), 64'd0);
        chk("t6_cnt", 64'(mtMCCNT), 64'd0);
        edges_q.delete();
        repeat (1060) tick();
        chk("t6_edges", 64'(edges_q.size()), 64'd1);
        if (edges_q.size() == 1) chk("t6_edge_at", 64'(edges_q[0]), 64'd1051);

        // Random traffic against the model
        for (int i = 0; i < 6000; i++) begin
            mtMDF   = 9'($urandom);
            divLOAD = ($urandom_range(0, 63) == 0);
            divVAL  = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 12));
            rst     = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 15) == 0) begin
                mtDATAI = 36'({$urandom, $urandom});
                if ($urandom_range(0, 1) == 1) mtDATAI[4:1] = 4'hF;
                if ($urandom_range(0, 3) != 0) mtDATAI[0] = 1'b1;
                mr_write(mtDATAI);
            end else begin
                tick();
            end
        end
        rst = 1'b0; divLOAD = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
